// File: rtl/div_sequencer_pkg.sv
// Purpose: shared state encodings and default operand width for the divider and its control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_sequencer_pkg;

    // Default operand width; the result is twice this and the iteration count equals it.
    localparam int DIV_WIDTH = 32;

    // 3-bit encodings. The control unit uses the same values for its wait-state timing.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Purpose: start/operand/result bundle between the control unit (master) and the divider (slave).
// Latency: n/a (wires only).
// Backpressure: none; start is ignored by the slave while busy.
//   start       master->slave  request a divide
//   in_a, in_b  master->slave  dividend / divisor, two's complement
//   busy        slave->master  operation in flight
//   done        slave->master  one-cycle pulse, result valid from this cycle
//   div_by_zero slave->master  divisor was zero, held with result
//   result      slave->master  {remainder, quotient}
interface div_sequencer_if
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, in_a, in_b,
        input  busy, done, div_by_zero, result
    );

    modport slave (
        input  start, in_a, in_b,
        output busy, done, div_by_zero, result
    );
endinterface

// File: rtl/div_sequencer_step.sv
// Purpose: one combinational non-restoring division iteration on unsigned magnitudes.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
//   i_a / o_a  partial remainder, WIDTH+1 bits signed
//   i_q / o_q  dividend bits shifting out, quotient bits shifting in
//   i_m        divisor magnitude
module div_sequencer_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH:0] w_a_sh;
    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_a_next;

    // {A,Q} << 1: the top dividend bit moves into A.
    assign w_a_sh  = {i_a[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_m_ext = {1'b0, i_m};

    // Direction is chosen by the sign of A before the shift.
    assign w_a_next = i_a[WIDTH] ? (w_a_sh + w_m_ext) : (w_a_sh - w_m_ext);

    assign o_a = w_a_next;
    assign o_q = {i_q[WIDTH-2:0], ~w_a_next[WIDTH]};
endmodule

// File: rtl/div_sequencer.sv
// Purpose: multi-cycle signed divider, one non-restoring step per clock, result {remainder, quotient}.
// Latency: start accepted at edge 0 -> done in cycle WIDTH+3 (cycle 2 for a zero divisor).
// Backpressure: start is ignored while busy (no queuing); accepted again in IDLE or DONE.
//   i_clk  rising-edge clock
//   i_clr  synchronous active-high reset, discards any in-flight divide
//   i_bus  div_sequencer_if slave: start/in_a/in_b in, busy/done/div_by_zero/result out
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_clr,
    div_sequencer_if.slave     i_bus
);
    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_busy;
    logic               w_done;

    logic [WIDTH-1:0]   r_a_in;      // dividend as captured
    logic [WIDTH-1:0]   r_b_in;      // divisor as captured
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH:0]     r_acc;       // partial remainder A
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_dbz;

    logic [WIDTH:0]     w_step_a;
    logic [WIDTH-1:0]   w_step_q;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    // |v|; the most negative value maps to 2^(WIDTH-1), which is exact as unsigned.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? f_neg(v) : v;
    endfunction

    div_sequencer_step #(.WIDTH(WIDTH)) u_step (
        .i_a (r_acc),
        .i_q (r_q),
        .i_m (r_m),
        .o_a (w_step_a),
        .o_q (w_step_q)
    );

    // Final restore: the remainder magnitude lies in [0, M), so WIDTH bits suffice.
    assign w_rem_mag = r_acc[WIDTH] ? (r_acc[WIDTH-1:0] + r_m) : r_acc[WIDTH-1:0];
    // Truncation toward zero: quotient sign is the XOR of operand signs,
    // remainder takes the dividend's sign.
    assign w_quo = (r_neg_a ^ r_neg_b) ? f_neg(r_q) : r_q;
    assign w_rem = r_neg_a ? f_neg(w_rem_mag) : w_rem_mag;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_PREP;
                end
            end
            S_PREP: begin
                w_busy       = 1'b1;
                w_state_next = (r_b_in == '0) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy       = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (i_bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_PREP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_a_in   <= '0;
            r_b_in   <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_in  <= i_bus.in_a;
                r_b_in  <= i_bus.in_b;
                r_neg_a <= i_bus.in_a[WIDTH-1];
                r_neg_b <= i_bus.in_b[WIDTH-1];
                r_dbz   <= 1'b0;
            end
            case (r_state)
                S_PREP: begin
                    r_acc <= '0;
                    r_q   <= f_abs(r_a_in);
                    r_m   <= f_abs(r_b_in);
                    r_cnt <= '0;
                    if (r_b_in == '0) begin
                        r_result <= {r_a_in, {WIDTH{1'b1}}};
                        r_dbz    <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_acc <= w_step_a;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_result <= {w_rem, w_quo};
                end
                default: ;
            endcase
        end
    end

    assign i_bus.busy        = w_busy;
    assign i_bus.done        = w_done;
    assign i_bus.div_by_zero = r_dbz;
    assign i_bus.result      = r_result;
endmodule

// File: tb/tb_div_sequencer.sv
// Purpose: directed self-checking bench for div_sequencer (signed divide, zero divisor, overflow, clr, back-to-back).
// Latency: cycle k is the cycle ending at edge k, start accepted at edge 0; outputs sampled on the falling edge.
// Backpressure: checks that start while busy is ignored and that start in DONE is accepted.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int W = 32;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_fail;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_clr (clr),
        .i_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide; returns how many falling edges after the accept edge done first appeared.
    // Operands are scrambled right after capture to show they have no effect.
    task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        bus.start = 1'b1;
        bus.in_a  = a;
        bus.in_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in_a  = 32'hDEAD_BEEF;
        bus.in_b  = 32'h0000_0003;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [63:0] exp_res, input logic exp_dbz, input int exp_lat);
        int lat;
        issue_and_wait(a, b, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, exp_dbz});
        @(negedge clk);
        chk({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, "_done_1cyc"}, {63'd0, bus.done}, 64'd0);
        chk({tag, "_held"}, bus.result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_done;
        n_cmp     = 0;
        n_fail    = 0;
        clr       = 1'b1;
        bus.start = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   {63'd0, bus.busy},        64'd0);
        chk("reset_done",   {63'd0, bus.done},        64'd0);
        chk("reset_dbz",    {63'd0, bus.div_by_zero}, 64'd0);
        chk("reset_result", bus.result,               64'd0);
        clr = 1'b0;

        // Basic and signed cases; normal latency is W+3 = 35.
        run_div("d100_7",   32'd100,        32'd7,          {32'd2,          32'd14},         1'b0, 35);
        run_div("dm100_7",  32'hFFFF_FF9C,  32'd7,          {32'hFFFF_FFFE,  32'hFFFF_FFF2},  1'b0, 35);
        run_div("d100_m7",  32'd100,        32'hFFFF_FFF9,  {32'd2,          32'hFFFF_FFF2},  1'b0, 35);
        run_div("dm7_m2",   32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF,  32'd3},          1'b0, 35);
        run_div("d3_100",   32'd3,          32'd100,        {32'd3,          32'd0},          1'b0, 35);

        // Zero divisor, then the flag clears on the next accepted start.
        run_div("d5_0",     32'd5,          32'd0,          {32'd5,          32'hFFFF_FFFF},  1'b1, 2);
        run_div("d9_3",     32'd9,          32'd3,          {32'd0,          32'd3},          1'b0, 35);

        // Overflow corner: most negative / -1.
        run_div("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000},  1'b0, 35);

        // start while busy is ignored.
        bus.start = 1'b1;
        bus.in_a  = 32'd100;
        bus.in_b  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 10) begin
                bus.start = 1'b1;
                bus.in_a  = 32'd1;
                bus.in_b  = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        chk("ign_latency", 64'(lat), 64'd35);
        chk("ign_result",  bus.result, {32'd2, 32'd14});
        @(negedge clk);
        chk("ign_busy_after", {63'd0, bus.busy}, 64'd0);

        // clr mid-operation: back to IDLE, outputs cleared, no done pulse.
        bus.start = 1'b1;
        bus.in_a  = 32'd100;
        bus.in_b  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k < 20; k++) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_busy",   {63'd0, bus.busy},        64'd0);
        chk("clr_result", bus.result,               64'd0);
        chk("clr_dbz",    {63'd0, bus.div_by_zero}, 64'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        chk("clr_no_done", 64'(n_done), 64'd0);

        // Back-to-back: start held through DONE, second op accepted in the DONE cycle.
        bus.start = 1'b1;
        bus.in_a  = 32'd50;
        bus.in_b  = 32'd5;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("b2b_first_latency", 64'(lat), 64'd35);
        chk("b2b_first_result",  bus.result, {32'd0, 32'd10});
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                bus.start = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        chk("b2b_second_latency", 64'(lat), 64'd35);
        chk("b2b_second_result",  bus.result, {32'd0, 32'd10});
        @(negedge clk);
        chk("b2b_busy_after", {63'd0, bus.busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
